capture_align_ctrl: RTL and testbench
=====================================

Name: capture_align_ctrl

Overview:
Alignment sequencer for the DCM-clocked 8-bit capture datapath. It holds the datapath in reset until the DCM reports lock and settles, then checks the incrementing training pattern on the captured bus. It steps the DCM fine phase shift until the pattern is clean, declares alignment, and monitors for loss of alignment afterwards. It sits between the DCM (locked, phase-shift port) and the capture datapath (reset, captured data).

Parameters:
SETTLE_CYC, 16, cycles to wait after lock before releasing dp_rst (1..255)
DP_LAT, 2, cycles after entering CHECK during which rxdata is ignored (datapath pipeline flush, 0..15)
CHECK_LEN, 64, consecutive passing compares required to declare alignment (1..1023)
MAX_TAPS, 32, maximum phase-shift steps before declaring failure (1..255)
LOSS_THRESH, 4, consecutive mismatches in ALIGNED that trigger a recheck (1..15)

Ports:
clkin  in  1  system clock, rising edge
rstin  in  1  asynchronous reset, active-low
locked  in  1  DCM lock indication, synchronous to clkin
rxdata  in  8  captured data from datapath
ps_done  in  1  DCM phase-shift done, one-cycle pulse
dp_rst  out  1  datapath reset, active-high
ps_en  out  1  DCM phase-shift enable, one-cycle pulse
ps_incdec  out  1  phase-shift direction, tied 1 (increment)
aligned  out  1  pattern verified at current tap
fail  out  1  MAX_TAPS exhausted, sticky
tap_cnt  out  8  phase-shift steps issued since last lock acquisition

Behaviour:
- All outputs registered. While rstin=0: state WAIT_LOCK, dp_rst=1, ps_en=0, ps_incdec=1, aligned=0, fail=0, tap_cnt=0, all internal counters 0.
- States are WAIT_LOCK, SETTLE, CHECK, SHIFT_REQ, SHIFT_WAIT, ALIGNED, FAIL.
- WAIT_LOCK: dp_rst=1. If locked=1 at edge k, go to SETTLE.
- SETTLE: dp_rst=1. Counts SETTLE_CYC cycles, then CHECK. dp_rst falls at edge k+SETTLE_CYC.
- CHECK: dp_rst=0.
  - First DP_LAT cycles ignored.
  - Next cycle loads prev=rxdata, with no compare.
  - Each following cycle: pass if rxdata == prev+1 modulo 256 (0xFF to 0x00 passes); prev is updated every cycle.
  - CHECK_LEN consecutive passes: go to ALIGNED, and aligned=1 on that edge.
  - Any mismatch: abort immediately to SHIFT_REQ.
- SHIFT_REQ:
  - If tap_cnt == MAX_TAPS, go to FAIL.
  - Otherwise ps_en=1 for exactly one cycle, tap_cnt increments, go to SHIFT_WAIT.
- SHIFT_WAIT: waits for ps_done (no timeout). ps_done=1 returns to CHECK with the DP_LAT ignore and load restarted. ps_done outside SHIFT_WAIT is ignored.
- ALIGNED:
  - aligned=1 and the pattern compare continues.
  - A mismatch counter increments on each mismatch and clears on a pass.
  - Reaching LOSS_THRESH: aligned=0 and go to CHECK. tap_cnt is unchanged, no DP_LAT wait, reload prev.
- FAIL: fail=1, dp_rst=0, sticky until rstin=0 or lock loss.
- Lock loss: locked=0 in any state except WAIT_LOCK forces WAIT_LOCK on the next edge.
  - Sets dp_rst=1.
  - Clears aligned, fail, tap_cnt, ps_en and all counters.
  - Takes priority over every other transition in the same cycle, including ps_done and the final passing compare.
- Reset mid-operation: asynchronous return to the reset values above; any in-flight ps_en pulse is truncated.

Optional Feature:
ALIGN_STATS_EN
- Defined:
  - Adds output err_cnt [15:0]: count of mismatches seen in ALIGNED, saturating at 0xFFFF.
  - Cleared by reset and by lock loss; not cleared by a recheck.
  - Adds output shift_evt [7:0]: count of ALIGNED-to-CHECK rechecks, saturating at 0xFF.
- Undefined: both ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Lock with clean pattern: rstin low 50 ns, then high; locked=1 at cycle 10; rxdata increments each cycle from dp_rst release -> dp_rst falls at cycle 26; aligned=1 after 26+2+1+64 cycles; tap_cnt=0; ps_en never pulses.
- Bad phase for 3 taps: corrupt rxdata (hold constant 0x55) until the 3rd ps_done, ps_done 5 cycles after each ps_en -> exactly 3 single-cycle ps_en pulses, tap_cnt=3, then aligned=1, fail=0.
- Exhaustion: MAX_TAPS=4, rxdata constant -> 4 ps_en pulses, tap_cnt=4, fail=1 and sticky, aligned=0.
- Wrap and loss: aligned, pattern passes through 0xFF->0x00 (aligned stays 1); then inject 4 consecutive bad values -> aligned=0 and recheck entered; with ALIGN_STATS_EN, err_cnt=4 and shift_evt=1.
- Lock loss: drop locked during SHIFT_WAIT with ps_done on the same cycle -> WAIT_LOCK, dp_rst=1, tap_cnt=0, no return to CHECK.
- Async reset mid-CHECK: rstin low between clock edges -> outputs reach reset values immediately, without waiting for a clkin edge.

Source files
------------

// File: rtl/capture_align_ctrl_if.sv
// ---------------------------------------------------------------------------
// capture_align_ctrl_if
// Bundles the DCM / capture-datapath side signals of the alignment
// sequencer into one interface.
//
// Signals:
//   locked     DCM lock indication (into controller)
//   rxdata     captured 8-bit data from the datapath (into controller)
//   ps_done    DCM phase-shift done pulse (into controller)
//   dp_rst     datapath reset, active-high (from controller)
//   ps_en      DCM phase-shift enable pulse (from controller)
//   ps_incdec  phase-shift direction, always increment (from controller)
//   aligned    training pattern verified at current tap (from controller)
//   fail       all taps exhausted, sticky (from controller)
//   tap_cnt    phase-shift steps issued since lock acquisition (from controller)
//   err_cnt    mismatches seen while aligned   (only with ALIGN_STATS_EN)
//   shift_evt  aligned-to-recheck events        (only with ALIGN_STATS_EN)
//
// Modports: master = the sequencer, slave = DCM / datapath side.
// Optional build macro: ALIGN_STATS_EN adds the statistics signals.
// ---------------------------------------------------------------------------
interface capture_align_ctrl_if;
    logic       locked;
    logic [7:0] rxdata;
    logic       ps_done;
    logic       dp_rst;
    logic       ps_en;
    logic       ps_incdec;
    logic       aligned;
    logic       fail;
    logic [7:0] tap_cnt;
`ifdef ALIGN_STATS_EN
    logic [15:0] err_cnt;
    logic [7:0]  shift_evt;

    modport master (
        input  locked, rxdata, ps_done,
        output dp_rst, ps_en, ps_incdec, aligned, fail, tap_cnt,
        output err_cnt, shift_evt
    );
    modport slave (
        output locked, rxdata, ps_done,
        input  dp_rst, ps_en, ps_incdec, aligned, fail, tap_cnt,
        input  err_cnt, shift_evt
    );
`else
    modport master (
        input  locked, rxdata, ps_done,
        output dp_rst, ps_en, ps_incdec, aligned, fail, tap_cnt
    );
    modport slave (
        output locked, rxdata, ps_done,
        input  dp_rst, ps_en, ps_incdec, aligned, fail, tap_cnt
    );
`endif
endinterface

// File: rtl/capture_align_ctrl.sv
// ---------------------------------------------------------------------------
// capture_align_ctrl
// Alignment sequencer for the DCM-clocked 8-bit capture datapath. Holds the
// datapath in reset until the DCM locks and settles, checks the incrementing
// training pattern, steps the DCM fine phase until the pattern is clean,
// declares alignment and then watches for loss of alignment.
//
// Ports:
//   clkin   system clock, rising edge
//   rstin   asynchronous reset, active-low
//   bus     capture_align_ctrl_if.master (locked, rxdata, ps_done in;
//           dp_rst, ps_en, ps_incdec, aligned, fail, tap_cnt out;
//           err_cnt, shift_evt out when ALIGN_STATS_EN is defined)
//
// Optional build macro: ALIGN_STATS_EN (mismatch / recheck statistics).
// ---------------------------------------------------------------------------
module capture_align_ctrl #(
    parameter int SETTLE_CYC  = 16,
    parameter int DP_LAT      = 2,
    parameter int CHECK_LEN   = 64,
    parameter int MAX_TAPS    = 32,
    parameter int LOSS_THRESH = 4
) (
    input  logic                 clkin,
    input  logic                 rstin,
    capture_align_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_CHECK,
        ST_SHIFT_REQ,
        ST_SHIFT_WAIT,
        ST_ALIGNED,
        ST_FAILED
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  settle_q, settle_d;
    logic [3:0]  lat_q, lat_d;
    logic        loaded_q, loaded_d;
    logic [7:0]  prev_q, prev_d;
    logic [9:0]  pass_q, pass_d;
    logic [3:0]  miss_q, miss_d;
    logic [7:0]  tap_q, tap_d;
    logic        dp_rst_q, dp_rst_d;
    logic        ps_en_q, ps_en_d;
    logic        aligned_q, aligned_d;
    logic        fail_q, fail_d;
`ifdef ALIGN_STATS_EN
    logic [15:0] err_q, err_d;
    logic [7:0]  shift_q, shift_d;
`endif

    // 8-bit compare so 0xFF followed by 0x00 counts as a pass.
    logic pattern_ok;
    assign pattern_ok = (bus.rxdata == prev_q + 8'd1);

    // ---------------- state / counter / output registers ----------------
    always_ff @(posedge clkin or negedge rstin) begin
        if (!rstin) begin
            state_q   <= ST_WAIT_LOCK;
            settle_q  <= '0;
            lat_q     <= '0;
            loaded_q  <= 1'b0;
            prev_q    <= '0;
            pass_q    <= '0;
            miss_q    <= '0;
            tap_q     <= '0;
            dp_rst_q  <= 1'b1;
            ps_en_q   <= 1'b0;
            aligned_q <= 1'b0;
            fail_q    <= 1'b0;
`ifdef ALIGN_STATS_EN
            err_q     <= '0;
            shift_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            lat_q     <= lat_d;
            loaded_q  <= loaded_d;
            prev_q    <= prev_d;
            pass_q    <= pass_d;
            miss_q    <= miss_d;
            tap_q     <= tap_d;
            dp_rst_q  <= dp_rst_d;
            ps_en_q   <= ps_en_d;
            aligned_q <= aligned_d;
            fail_q    <= fail_d;
`ifdef ALIGN_STATS_EN
            err_q     <= err_d;
            shift_q   <= shift_d;
`endif
        end
    end

    // ---------------- next-state and counter logic ----------------
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        lat_d    = lat_q;
        loaded_d = loaded_q;
        // prev only matters once loaded; tracking rxdata every cycle keeps
        // both the load and the per-cycle update trivially correct.
        prev_d   = bus.rxdata;
        pass_d   = pass_q;
        miss_d   = miss_q;
        tap_d    = tap_q;
`ifdef ALIGN_STATS_EN
        err_d    = err_q;
        shift_d  = shift_q;
`endif
        case (state_q)
            ST_WAIT_LOCK: begin
                if (bus.locked) begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                end
            end
            ST_SETTLE: begin
                if (settle_q == 8'(SETTLE_CYC - 1)) begin
                    state_d  = ST_CHECK;
                    lat_d    = '0;
                    loaded_d = 1'b0;
                    pass_d   = '0;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            ST_CHECK: begin
                if (lat_q != 4'(DP_LAT)) begin
                    lat_d = lat_q + 4'd1;          // pipeline flush, data ignored
                end else if (!loaded_q) begin
                    loaded_d = 1'b1;               // reference sample, no compare
                end else if (pattern_ok) begin
                    if (pass_q == 10'(CHECK_LEN - 1)) begin
                        state_d = ST_ALIGNED;
                        miss_d  = '0;
                    end else begin
                        pass_d = pass_q + 10'd1;
                    end
                end else begin
                    state_d = ST_SHIFT_REQ;
                end
            end
            ST_SHIFT_REQ: begin
                if (tap_q == 8'(MAX_TAPS)) begin
                    state_d = ST_FAILED;
                end else begin
                    state_d = ST_SHIFT_WAIT;
                    tap_d   = tap_q + 8'd1;
                end
            end
            ST_SHIFT_WAIT: begin
                if (bus.ps_done) begin
                    state_d  = ST_CHECK;
                    lat_d    = '0;
                    loaded_d = 1'b0;
                    pass_d   = '0;
                end
            end
            ST_ALIGNED: begin
                if (pattern_ok) begin
                    miss_d = '0;
                end else begin
`ifdef ALIGN_STATS_EN
                    if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
`endif
                    if (miss_q == 4'(LOSS_THRESH - 1)) begin
                        // Recheck at the same tap: datapath is already
                        // flushed, so skip the latency wait and just reload.
                        state_d  = ST_CHECK;
                        miss_d   = '0;
                        lat_d    = 4'(DP_LAT);
                        loaded_d = 1'b0;
                        pass_d   = '0;
`ifdef ALIGN_STATS_EN
                        if (shift_q != 8'hFF) shift_d = shift_q + 8'd1;
`endif
                    end else begin
                        miss_d = miss_q + 4'd1;
                    end
                end
            end
            ST_FAILED: state_d = ST_FAILED;
            default:   state_d = ST_WAIT_LOCK;
        endcase

        // Lock loss overrides every other transition, including ps_done
        // and the final passing compare.
        if (!bus.locked) begin
            state_d  = ST_WAIT_LOCK;
            settle_d = '0;
            lat_d    = '0;
            loaded_d = 1'b0;
            pass_d   = '0;
            miss_d   = '0;
            tap_d    = '0;
`ifdef ALIGN_STATS_EN
            err_d    = '0;
            shift_d  = '0;
`endif
        end
    end

    // ---------------- registered output decode ----------------
    always_comb begin
        dp_rst_d  = (state_d == ST_WAIT_LOCK) || (state_d == ST_SETTLE);
        ps_en_d   = (state_q == ST_SHIFT_REQ) && (state_d == ST_SHIFT_WAIT);
        aligned_d = (state_d == ST_ALIGNED);
        fail_d    = (state_d == ST_FAILED);
    end

    assign bus.dp_rst    = dp_rst_q;
    assign bus.ps_en     = ps_en_q;
    assign bus.ps_incdec = 1'b1;
    assign bus.aligned   = aligned_q;
    assign bus.fail      = fail_q;
    assign bus.tap_cnt   = tap_q;
`ifdef ALIGN_STATS_EN
    assign bus.err_cnt   = err_q;
    assign bus.shift_evt = shift_q;
`endif

endmodule

// File: tb/tb_capture_align_ctrl.sv
// ---------------------------------------------------------------------------
// tb_capture_align_ctrl
// Self-checking bench for capture_align_ctrl (MAX_TAPS overridden to 4).
// A table of phase-search scenarios feeds a scoreboard queue; hand-written
// sequences cover exact release/align timing, pattern wrap and loss, lock
// loss during a shift, and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_capture_align_ctrl;

    logic clkin = 1'b0;
    logic rstin = 1'b0;

    capture_align_ctrl_if bus();

    capture_align_ctrl #(
        .SETTLE_CYC (16),
        .DP_LAT     (2),
        .CHECK_LEN  (64),
        .MAX_TAPS   (4),
        .LOSS_THRESH(4)
    ) dut (
        .clkin(clkin),
        .rstin(rstin),
        .bus  (bus.master)
    );

    always #5 clkin = ~clkin;

    typedef struct {
        string name;
        int    bad_taps;
        int    pulses;
        int    tap;
        int    aligned;
        int    fail;
    } vec_t;

    vec_t vecs[4];
    vec_t sb[$];

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int pulses     = 0;
    int en_run_err = 0;
    int done_cnt   = 0;
    int done_base  = 0;
    int bad_taps   = 0;
    bit bad_mode   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Edge counter: value n after the n-th rising edge.
    initial forever begin
        @(posedge clkin);
        cyc = cyc + 1;
    end

    // Datapath model: incrementing training pattern, or constant 0x55
    // while the phase is "bad".
    initial begin
        bus.rxdata = 8'h00;
        forever begin
            @(posedge clkin);
            #1;
            if (bad_mode || ((done_cnt - done_base) < bad_taps))
                bus.rxdata = 8'h55;
            else
                bus.rxdata = bus.rxdata + 8'd1;
        end
    end

    // DCM phase-shift model: ps_done 5 cycles after each ps_en.
    initial begin
        int  cd;
        bit  prev_en;
        cd = 0;
        prev_en = 1'b0;
        bus.ps_done = 1'b0;
        forever begin
            @(posedge clkin);
            #1;
            bus.ps_done = 1'b0;
            if (!rstin || !bus.locked) cd = 0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    bus.ps_done = 1'b1;
                    done_cnt++;
                end
            end
            if (bus.ps_en === 1'b1) begin
                pulses++;
                if (prev_en) en_run_err++;
                cd = 5;
            end
            prev_en = (bus.ps_en === 1'b1);
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dp_rst"},    bus.dp_rst,    1);
        chk({tag, "_ps_en"},     bus.ps_en,     0);
        chk({tag, "_ps_incdec"}, bus.ps_incdec, 1);
        chk({tag, "_aligned"},   bus.aligned,   0);
        chk({tag, "_fail"},      bus.fail,      0);
        chk({tag, "_tap_cnt"},   bus.tap_cnt,   0);
`ifdef ALIGN_STATS_EN
        chk({tag, "_err_cnt"},   bus.err_cnt,   0);
        chk({tag, "_shift_evt"}, bus.shift_evt, 0);
`endif
    endtask

    task automatic do_reset();
        @(posedge clkin);
        #3;
        rstin = 1'b0;
        bus.locked = 1'b0;
        bad_mode = 1'b0;
        bad_taps = 0;
        repeat (2) @(posedge clkin);
        #1;
        chk_reset_vals("rst");
        #2;
        rstin = 1'b1;
        done_base = done_cnt;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   n;
        int   first_rel;
        int   first_al;
        int   pbase;
        int   bad_seen;

        vecs[0] = '{"bad3",        3, 3, 3, 1, 0};
        vecs[1] = '{"bad1",        1, 1, 1, 1, 0};
        vecs[2] = '{"exhaust",    99, 4, 4, 0, 1};
        vecs[3] = '{"bad4_align",  4, 4, 4, 1, 0};

        // ---- Sequence 1: clean lock, exact release and alignment edges ----
        bus.locked = 1'b0;
        rstin = 1'b0;
        #20;
        chk_reset_vals("por");
        #30;
        rstin = 1'b1;
        while (cyc < 9) @(posedge clkin);
        #1;
        bus.locked = 1'b1;                 // sampled at edge 10
        sb.push_back('{"clean", 0, 0, 0, 1, 0});
        first_rel = -1;
        first_al  = -1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clkin);
            #1;
            if (first_rel < 0 && bus.dp_rst == 1'b0) first_rel = cyc;
            if (bus.aligned == 1'b1) begin
                first_al = cyc;
                break;
            end
        end
        chk("clean_release_edge", first_rel, 26);
        chk("clean_align_edge", first_al, 93);
        v = sb.pop_front();
        chk({v.name, "_pulses"},  pulses,      v.pulses);
        chk({v.name, "_tap"},     bus.tap_cnt, v.tap);
        chk({v.name, "_fail"},    bus.fail,    v.fail);
        chk({v.name, "_aligned"}, bus.aligned, v.aligned);

        // ---- Sequence 2: pattern wrap, then loss of alignment ----
        n = 0;
        while (n < 300) begin
            @(posedge clkin);
            #2;
            n++;
            if (bus.rxdata == 8'hFF) break;
        end
        chk("wrap_seen_in_budget", (n < 300) ? 1 : 0, 1);
        repeat (4) @(posedge clkin);
        #1;
        chk("wrap_aligned", bus.aligned, 1);
        #1;
        bad_mode = 1'b1;
        repeat (4) @(posedge clkin);
        #2;
        bad_mode = 1'b0;
        chk("loss_3miss_aligned", bus.aligned, 1);
        @(posedge clkin);
        #1;
        chk("loss_4miss_aligned", bus.aligned, 0);
        chk("loss_dp_rst", bus.dp_rst, 0);
`ifdef ALIGN_STATS_EN
        chk("loss_err_cnt", bus.err_cnt, 4);
        chk("loss_shift_evt", bus.shift_evt, 1);
`endif
        n = 0;
        while (n < 200) begin
            @(posedge clkin);
            #1;
            n++;
            if (bus.aligned == 1'b1) break;
        end
        chk("realign_edges", n, 65);
        chk("realign_tap", bus.tap_cnt, 0);
        chk("realign_no_pulse", pulses, 0);

        // ---- Table-driven phase search scenarios ----
        for (int i = 0; i < 4; i++) begin
            do_reset();
            bad_taps = vecs[i].bad_taps;
            pbase = pulses;
            sb.push_back(vecs[i]);
            @(posedge clkin);
            #1;
            bus.locked = 1'b1;
            n = 0;
            while (n < 2000) begin
                @(posedge clkin);
                #1;
                n++;
                if (bus.aligned == 1'b1 || bus.fail == 1'b1) break;
            end
            chk({vecs[i].name, "_in_budget"}, (n < 2000) ? 1 : 0, 1);
            repeat (20) @(posedge clkin);
            #1;
            v = sb.pop_front();
            $display("scenario %s: taps=%0d aligned=%0d fail=%0d pulses=%0d",
                     v.name, bus.tap_cnt, bus.aligned, bus.fail, pulses - pbase);
            chk({v.name, "_pulses"},  pulses - pbase, v.pulses);
            chk({v.name, "_tap"},     bus.tap_cnt,    v.tap);
            chk({v.name, "_aligned"}, bus.aligned,    v.aligned);
            chk({v.name, "_fail"},    bus.fail,       v.fail);
            chk({v.name, "_dp_rst"},  bus.dp_rst,     0);
            chk({v.name, "_pulse_width"}, en_run_err, 0);
        end

        // ---- Lock loss during SHIFT_WAIT coinciding with ps_done ----
        do_reset();
        bad_taps = 99;
        @(posedge clkin);
        #1;
        bus.locked = 1'b1;
        n = 0;
        while (n < 500) begin
            @(posedge clkin);
            #2;
            n++;
            if (bus.ps_done == 1'b1) break;
        end
        chk("ll_done_in_budget", (n < 500) ? 1 : 0, 1);
        chk("ll_tap_before", bus.tap_cnt, 1);
        bus.locked = 1'b0;                 // sampled with ps_done
        @(posedge clkin);
        #1;
        chk("ll_dp_rst", bus.dp_rst, 1);
        chk("ll_tap", bus.tap_cnt, 0);
        chk("ll_aligned", bus.aligned, 0);
        chk("ll_ps_en", bus.ps_en, 0);
        bad_seen = 0;
        repeat (10) begin
            @(posedge clkin);
            #1;
            if (bus.dp_rst != 1'b1 || bus.ps_en != 1'b0) bad_seen++;
        end
        chk("ll_stays_waiting", bad_seen, 0);

        // ---- Asynchronous reset mid-CHECK ----
        do_reset();
        bad_taps = 1;
        @(posedge clkin);
        #1;
        bus.locked = 1'b1;
        n = 0;
        while (n < 500 && (done_cnt - done_base) < 1) begin
            @(posedge clkin);
            #2;
            n++;
        end
        chk("ar_done_in_budget", (n < 500) ? 1 : 0, 1);
        repeat (2) @(posedge clkin);
        #1;
        chk("ar_pre_dp_rst", bus.dp_rst, 0);
        chk("ar_pre_tap", bus.tap_cnt, 1);
        #2;
        rstin = 1'b0;                      // between edges
        #1;
        chk("ar_dp_rst", bus.dp_rst, 1);
        chk("ar_tap", bus.tap_cnt, 0);
        chk("ar_aligned", bus.aligned, 0);

        // ---- Asynchronous reset truncating a ps_en pulse ----
        do_reset();
        bad_taps = 99;
        @(posedge clkin);
        #1;
        bus.locked = 1'b1;
        n = 0;
        while (n < 500) begin
            @(posedge clkin);
            #2;
            n++;
            if (bus.ps_en == 1'b1) break;
        end
        chk("trunc_pulse_in_budget", (n < 500) ? 1 : 0, 1);
        rstin = 1'b0;
        #1;
        chk("trunc_ps_en", bus.ps_en, 0);
        chk("trunc_tap", bus.tap_cnt, 0);
        chk("trunc_dp_rst", bus.dp_rst, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
